// File: rtl/mult_seq.sv
// Unsigned 32x32->64 shift-add multiplier, one step per clock through a single 32-bit adder.
// Result 32 cycles after accept; holds product in DONE under out_ready backpressure, in_ready low until IDLE.

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  count_q, count_d;

    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        carry;

    adder u_adder (
        .a   (hi_q),
        .b   (add_b),
        .sum (add_sum)
    );

    assign add_b = lo_q[0] ? mcand_q : 32'd0;
    // The adder has no carry-out; a wrapped sum is always smaller than either operand.
    assign carry = (add_sum < hi_q);

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = {hi_q, lo_q};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 32'd0;
                    count_d = 5'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                {hi_d, lo_d} = {carry, add_sum, lo_q[31:1]};
                count_d      = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// Scoreboarded bench for mult_seq: directed corner cases, backpressure, async abort, random traffic.

module tb_mult_seq;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair, then wait for and consume its result with out_ready=1.
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b, input string tag);
        int n;
        logic [63:0] e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = op_a;
        b = op_b;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        exp_q.push_back(64'(op_a) * 64'(op_b));
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd32);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_product"}, product, e);
        tick();
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    logic [63:0] held;
    int n_out;
    int n_in;
    int cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        #3;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", product, 64'd0);
        #20;
        rst = 1'b0;
        tick();
        chk("idle_product", product, 64'd0);

        do_op(32'd3, 32'd5, "small");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
        do_op(32'h8000_0000, 32'd2, "carry");
        do_op(32'h1234_5678, 32'd0, "b_zero");
        do_op(32'd0, 32'hDEAD_BEEF, "a_zero");

        // Backpressure, plus operand pulses in BUSY and DONE that must be ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 32'hCAFE_0001;
        b = 32'h0000_1003;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd9;
        chk("bp_busy_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp_latency", 64'(cyc), 64'd26);
        held = 64'(32'hCAFE_0001) * 64'(32'h0000_1003);
        chk("bp_product", product, held);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            a = 32'd11;
            b = 32'd13;
            tick();
            in_valid = 1'b0;
            if (i == 3 || i == 9) begin
                chk("bp_done_valid", 64'(out_valid), 64'd1);
                chk("bp_done_product", product, held);
                chk("bp_done_in_ready", 64'(in_ready), 64'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        repeat (3) tick();
        chk("bp_no_ghost_valid", 64'(out_valid), 64'd0);
        chk("bp_no_ghost_ready", 64'(in_ready), 64'd1);

        // Abort mid-operation with an asynchronous reset.
        in_valid = 1'b1;
        a = 32'hFFFF_0000;
        b = 32'h0F0F_0F0F;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        chk("abort_busy", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_product", product, 64'd0);
        #4 rst = 1'b0;
        tick();
        do_op(32'd7, 32'd9, "after_abort");

        // Random back-to-back traffic with random output stalls.
        n_out = 0;
        n_in  = 0;
        fork
            begin
                for (int i = 0; i < 1024; i++) begin
                    logic acc;
                    int   w;
                    logic [31:0] ra;
                    logic [31:0] rb;
                    ra = $random;
                    rb = $random;
                    in_valid = 1'b1;
                    a = ra;
                    b = rb;
                    w = 0;
                    do begin
                        acc = in_ready;
                        tick();
                        w++;
                    end while (!acc && w < 400);
                    if (!acc) begin
                        chk("rand_accept_timeout", 64'(w), 64'd0);
                        break;
                    end
                    exp_q.push_back(64'(ra) * 64'(rb));
                    n_in++;
                    in_valid = 1'b0;
                    a = $urandom;
                    b = $urandom;
                end
                in_valid = 1'b0;
            end
            begin
                logic [63:0] e;
                cyc = 0;
                while (n_out < 1024 && cyc < 80000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        else e = ~product;
                        chk("rand_product", product, e);
                        n_out++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        repeat (40) tick();
        chk("rand_inputs", 64'(n_in), 64'd1024);
        chk("rand_outputs", 64'(n_out), 64'd1024);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_no_extra_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Iterative unsigned 32x32->64 multiplier for the march datapath, built on one instance of the existing 32-bit `adder`.
- Performs one shift-add step per clock.
- Feeds that adder its operands each cycle and consumes its sum.
- Sits beside the ALU in execute and serves MUL/MULHU via valid/ready handshakes on both sides.

Parameters:
None. Width is fixed at 32 to match `adder`.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  32  multiplicand, unsigned
b  input  32  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  64  a*b, unsigned, full width

Behaviour:
- Internal registers:
  - state: IDLE, BUSY or DONE.
  - mcand[31:0], hi[31:0], lo[31:0].
  - count[4:0].
- Reset (async, rst=1):
  - state=IDLE; mcand, hi, lo and count all cleared to 0.
  - Outputs: in_ready=1, out_valid=0, product=0.
  - Reset asserted mid-operation aborts that operation. No result is ever emitted for it.
- Output decode:
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - product = {hi,lo}. It must be 0 while IDLE after reset; holding the last product while IDLE is also acceptable.
- IDLE:
  - On in_valid&&in_ready: mcand<=a, lo<=b, hi<=0, count<=0, state<=BUSY.
  - Otherwise hold.
- BUSY, once per clock:
  - Adder inputs: adder.a=hi, adder.b=(lo[0] ? mcand : 0).
  - carry = (adder.sum < hi). This is an unsigned compare; `adder` has no carry-out.
  - {hi,lo} <= {carry, adder.sum, lo[31:1]}.
  - count<=count+1.
  - When count==31: state<=DONE. The wrap to 0 is harmless.
- DONE:
  - product is held stable while out_valid=1 && out_ready=0 (backpressure of any length).
  - On out_valid&&out_ready: state<=IDLE.
- Latency:
  - The acceptance edge loads registers. The following 32 edges are BUSY steps.
  - out_valid rises after the 32nd edge following the acceptance edge, i.e. 32 cycles.
  - Minimum initiation interval is 34 cycles: accept, 32 busy cycles, 1 DONE cycle with out_ready=1.
- Handshake rules:
  - in_valid while in BUSY or DONE is ignored; the operands are not latched.
  - in_ready=0 in DONE, so an output handshake and the next input accept can never happen on the same edge. The next accept is possible one cycle after IDLE is re-entered.
  - a and b are sampled only on the accept edge. Changes afterwards do not affect the result.
  - out_ready is ignored outside DONE.
- Arithmetic:
  - Exact unsigned result for all inputs. No overflow is possible in 64 bits.
  - hi+mcand never exceeds 33 bits.

Test Plan:
- After reset: in_ready=1, out_valid=0, product=0. Accept a=3, b=5 with out_ready=1 -> out_valid exactly 32 cycles after the accept edge, product=0x000000000000000F, in_ready=1 on the following cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Also a=0x80000000, b=2 -> 0x0000000100000000 (carry path exercised).
- a=0x12345678, b=0 and a=0, b=0xDEADBEEF -> product=0. Latency is still 32 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and product constant. Pulse in_valid with new operands during BUSY and during DONE -> ignored, in_ready=0. Release out_ready -> one handshake, then IDLE.
- Reset mid-operation: assert rst at cycle 15 of BUSY -> outputs return to reset values immediately (async). A later accept of a=7, b=9 -> product=63.
- 1024 random ($random) operand pairs, back-to-back with random out_ready stalls -> every product equals the 64-bit a*b computed by the bench, and each input produces exactly one output.
